// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory/LSU port between the pipeline MEM stage
// (core) and a debug/loader requester. The core has priority. When the
// optional starvation guard is built in, a debug request that has waited
// STARVE_MAX consecutive cycles is forced through. The core is stalled for
// that one cycle. Debug reads return registered data one cycle after grant.
//
// Build option:
//   DMEM_ARB_STARVE_EN  - when defined, enables the starvation counter,
//                         forced grants, core_stall and stall_cnt. When
//                         undefined, the core has strict priority,
//                         core_stall is 0 and stall_cnt reads 0.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   core_rd/wr/addr/
//   core_wdata/func3     MEM-stage access from the pipeline
//   core_rdata           load data to the pipeline (straight from mem_rdata)
//   core_stall           hold MEM and earlier stages this cycle
//   dbg_req/we/addr/
//   dbg_wdata            debug access request, held until granted
//   dbg_gnt              debug access performed this cycle
//   dbg_rvalid/rdata     registered read response, one cycle after grant
//   mem_*                LSU port (mem_rdata is the combinational response)
//   stall_cnt            saturating count of forced-stall cycles
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int SCNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [2:0]        core_func3,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [SCNT_W-1:0] stall_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    localparam logic [2:0] LP_FUNC3_WORD = 3'b010;

    logic              w_core_act;
    logic              w_dbg_gnt;
    logic              w_dbg_rd_gnt;
    state_t            r_state;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_dbg_rdata;

    assign w_core_act   = core_rd | core_wr;
    assign w_dbg_rd_gnt = w_dbg_gnt & ~dbg_we;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    logic [3:0]        r_starve;
    logic [SCNT_W-1:0] r_stall_cnt;
    logic              w_forced;

    assign w_forced   = (r_starve == LP_STARVE_MAX);
    assign w_dbg_gnt  = dbg_req & (~w_core_act | w_forced);
    assign core_stall = w_core_act & w_dbg_gnt;
    assign stall_cnt  = r_stall_cnt;

    // Counts consecutive cycles of a pending, ungranted request. Reaching
    // STARVE_MAX forces a grant, which clears it again, so the core always
    // gets at least STARVE_MAX cycles between forced stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_dbg_gnt || !dbg_req) begin
            r_starve <= '0;
        end else if (r_starve != LP_STARVE_MAX) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (core_stall && (r_stall_cnt != {SCNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end
`else
    // Strict core priority: debug only gets the idle cycles.
    assign w_dbg_gnt  = dbg_req & ~w_core_act;
    assign core_stall = 1'b0;
    assign stall_cnt  = '0;
`endif

    assign dbg_gnt    = w_dbg_gnt;
    assign core_rdata = mem_rdata;

    // Port mux. The core fields pass through untouched, including the
    // illegal rd&wr combination, so the LSU sees exactly what the pipeline
    // asked for.
    always_comb begin
        mem_rd    = core_rd;
        mem_wr    = core_wr;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_func3 = core_func3;
        if (w_dbg_gnt) begin
            mem_rd    = ~dbg_we;
            mem_wr    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_func3 = LP_FUNC3_WORD;
        end
    end

    // Read response: capture the LSU data on a read grant and present it for
    // one cycle. A new read grant while responding recaptures and stays in
    // RESP, so back-to-back reads give a continuous rvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_dbg_rd_gnt) begin
                        r_state      <= S_RESP;
                        r_dbg_rvalid <= 1'b1;
                        r_dbg_rdata  <= mem_rdata;
                    end
                end
                S_RESP: begin
                    if (w_dbg_rd_gnt) begin
                        r_state      <= S_RESP;
                        r_dbg_rvalid <= 1'b1;
                        r_dbg_rdata  <= mem_rdata;
                    end else begin
                        r_state      <= S_IDLE;
                        r_dbg_rvalid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dbg_rvalid <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_rvalid = r_dbg_rvalid;
    assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int SCNT_W     = 16;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              core_rd, core_wr;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [2:0]        core_func3;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt, dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_func3;
    logic [DATA_W-1:0] mem_rdata;
    logic [SCNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .SCNT_W(SCNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_func3(core_func3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    task automatic set_idle();
        core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_func3 = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        mem_rdata = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic e_gnt;
        reset = 1'b1;
        core_rd = 1'($urandom); core_wr = 1'($urandom); core_addr = ADDR_W'($urandom);
        core_wdata = $urandom; core_func3 = 3'($urandom);
        dbg_req = 1'b1; dbg_we = 1'($urandom); dbg_addr = ADDR_W'($urandom);
        dbg_wdata = $urandom; mem_rdata = $urandom;
        @(negedge clk);
        e_gnt = !(core_rd || core_wr);
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got=%b want=0", dbg_rvalid); end
        n_cmp++; if (dbg_rdata !== '0) begin n_err++; $display("FAIL reset_rdata got=%h want=0", dbg_rdata); end
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        n_cmp++; if (dbg_gnt !== e_gnt) begin n_err++; $display("FAIL reset_gnt got=%b want=%b", dbg_gnt, e_gnt); end
        n_cmp++; if (mem_addr !== (e_gnt ? dbg_addr : core_addr)) begin n_err++; $display("FAIL reset_mem_addr got=%h", mem_addr); end
        n_cmp++; if (core_rdata !== mem_rdata) begin n_err++; $display("FAIL reset_core_rdata got=%h want=%h", core_rdata, mem_rdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
    endtask

`ifdef DMEM_ARB_STARVE_EN
    // Core busy every cycle, debug read held from cycle 0.
    task automatic test_starvation();
        bit e_gnt;
        int e_cnt;
        pulse_reset();
        for (int c = 0; c < 13; c++) begin
            core_rd = 1'b1; core_addr = ADDR_W'($urandom); mem_rdata = $urandom;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h055;
            @(negedge clk);
            e_gnt = (c == 4) || (c == 9);
            e_cnt = (c <= 4) ? 0 : ((c <= 9) ? 1 : 2);
            n_cmp++; if (dbg_gnt !== e_gnt) begin n_err++; $display("FAIL starve_gnt c=%0d got=%b want=%b", c, dbg_gnt, e_gnt); end
            n_cmp++; if (core_stall !== e_gnt) begin n_err++; $display("FAIL starve_stall c=%0d got=%b want=%b", c, core_stall, e_gnt); end
            n_cmp++; if (stall_cnt !== SCNT_W'(e_cnt)) begin n_err++; $display("FAIL starve_cnt c=%0d got=%0d want=%0d", c, stall_cnt, e_cnt); end
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask
`else
    task automatic test_strict_priority();
        pulse_reset();
        for (int c = 0; c < 50; c++) begin
            core_wr = 1'b1; core_addr = ADDR_W'($urandom); mem_rdata = $urandom;
            dbg_req = 1'b1; dbg_we = 1'b0;
            @(negedge clk);
            n_cmp++; if (dbg_gnt !== 1'b0 || core_stall !== 1'b0) begin n_err++; $display("FAIL strict_busy c=%0d gnt=%b stall=%b want 0/0", c, dbg_gnt, core_stall); end
            next_cycle();
        end
        core_wr = 1'b0;
        @(negedge clk);
        n_cmp++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL strict_idle_gnt got=%b want=1", dbg_gnt); end
        n_cmp++; if (stall_cnt !== '0) begin n_err++; $display("FAIL strict_cnt got=%0d want=0", stall_cnt); end
        next_cycle();
        set_idle();
        next_cycle();
    endtask
`endif

    task automatic test_core_load();
        set_idle();
        core_rd = 1'b1; core_addr = 10'h010; mem_rdata = 32'hCAFE0001;
        @(negedge clk);
        n_cmp++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL load_rdwr got=%b%b want=10", mem_rd, mem_wr); end
        n_cmp++; if (mem_addr !== 10'h010) begin n_err++; $display("FAIL load_addr got=%h want=010", mem_addr); end
        n_cmp++; if (core_rdata !== 32'hCAFE0001) begin n_err++; $display("FAIL load_rdata got=%h want=cafe0001", core_rdata); end
        n_cmp++; if (core_stall !== 1'b0 || dbg_gnt !== 1'b0) begin n_err++; $display("FAIL load_stall_gnt got=%b%b want=00", core_stall, dbg_gnt); end
        next_cycle();
        set_idle();
    endtask

    task automatic test_dbg_write();
        set_idle();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h3F0; dbg_wdata = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt got=%b want=1", dbg_gnt); end
        n_cmp++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin n_err++; $display("FAIL wr_rdwr got=%b%b want=01", mem_rd, mem_wr); end
        n_cmp++; if (mem_addr !== 10'h3F0) begin n_err++; $display("FAIL wr_addr got=%h want=3f0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_wdata got=%h want=deadbeef", mem_wdata); end
        n_cmp++; if (mem_func3 !== 3'b010) begin n_err++; $display("FAIL wr_func3 got=%b want=010", mem_func3); end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid got=%b want=0", dbg_rvalid); end
        next_cycle();
    endtask

    task automatic test_dbg_read();
        set_idle();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h123; mem_rdata = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (dbg_gnt !== 1'b1 || mem_rd !== 1'b1) begin n_err++; $display("FAIL rd_gnt gnt=%b mem_rd=%b want 1/1", dbg_gnt, mem_rd); end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++; if (dbg_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid got=%b want=1", dbg_rvalid); end
        n_cmp++; if (dbg_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata got=%h want=12345678", dbg_rdata); end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_end got=%b want=0", dbg_rvalid); end
        n_cmp++; if (dbg_rdata !== 32'h12345678) begin n_err++; $display("FAIL rd_rdata_hold got=%h want=12345678", dbg_rdata); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        set_idle();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = ADDR_W'(c * 4); mem_rdata = d[c];
            end else begin
                set_idle();
            end
            @(negedge clk);
            if (c < 4) begin
                n_cmp++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt c=%0d got=%b want=1", c, dbg_gnt); end
            end
            n_cmp++; if (dbg_rvalid !== (c >= 1 && c <= 4)) begin n_err++; $display("FAIL b2b_rvalid c=%0d got=%b", c, dbg_rvalid); end
            if (c >= 1 && c <= 4) begin
                n_cmp++; if (dbg_rdata !== d[c-1]) begin n_err++; $display("FAIL b2b_rdata c=%0d got=%h want=%h", c, dbg_rdata, d[c-1]); end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        // Build up a partial wait with the core busy, then a response in flight.
        for (int c = 0; c < 2; c++) begin
            core_rd = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
            next_cycle();
        end
        set_idle();
        dbg_req = 1'b1; dbg_we = 1'b0; mem_rdata = 32'hA5A5A5A5;
        next_cycle();
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL rmid_rvalid got=%b want=0", dbg_rvalid); end
        n_cmp++; if (dbg_rdata !== '0) begin n_err++; $display("FAIL rmid_rdata got=%h want=0", dbg_rdata); end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            core_rd = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
            @(negedge clk);
            n_cmp++; if (dbg_gnt !== (STARVE_EN && c == 4)) begin n_err++; $display("FAIL rmid_gnt c=%0d got=%b", c, dbg_gnt); end
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    // Random traffic against a transaction-level model: a request wins when
    // the core is idle or (guard enabled) when it has already waited
    // STARVE_MAX cycles; a read grant yields its data on the next cycle.
    task automatic test_random();
        int                wait_cyc = 0;
        int                scnt = 0;
        bit                e_rv = 0;
        logic [DATA_W-1:0] e_rdata = '0;
        bit                last_gnt = 0;
        bit                e_gnt, e_stall, act, e_rd, e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic [2:0]        e_f3;
        set_idle();
        pulse_reset();
        for (int c = 0; c < 2000; c++) begin
            if (dbg_req && !last_gnt) begin
                if ($urandom_range(0, 15) == 0) dbg_req = 1'b0;
            end else begin
                dbg_req = 1'($urandom); dbg_we = 1'($urandom);
                dbg_addr = ADDR_W'($urandom); dbg_wdata = $urandom;
            end
            act = ($urandom_range(0, 3) != 0);
            if (!act) begin
                core_rd = 0; core_wr = 0;
            end else if ($urandom_range(0, 15) == 0) begin
                core_rd = 1; core_wr = 1;
            end else begin
                core_rd = 1'($urandom); core_wr = !core_rd;
            end
            core_addr = ADDR_W'($urandom); core_wdata = $urandom;
            core_func3 = 3'($urandom); mem_rdata = $urandom;

            act     = core_rd || core_wr;
            e_gnt   = dbg_req && (!act || (STARVE_EN && wait_cyc == STARVE_MAX));
            e_stall = STARVE_EN && act && e_gnt;
            e_rd    = e_gnt ? !dbg_we : core_rd;
            e_wr    = e_gnt ? dbg_we : core_wr;
            e_addr  = e_gnt ? dbg_addr : core_addr;
            e_wdata = e_gnt ? dbg_wdata : core_wdata;
            e_f3    = e_gnt ? 3'b010 : core_func3;

            @(negedge clk);
            n_cmp++; if (dbg_gnt !== e_gnt) begin n_err++; $display("FAIL rnd_gnt c=%0d got=%b want=%b", c, dbg_gnt, e_gnt); end
            n_cmp++; if (core_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall c=%0d got=%b want=%b", c, core_stall, e_stall); end
            n_cmp++; if (mem_rd !== e_rd || mem_wr !== e_wr) begin n_err++; $display("FAIL rnd_rdwr c=%0d got=%b%b want=%b%b", c, mem_rd, mem_wr, e_rd, e_wr); end
            n_cmp++; if (mem_addr !== e_addr || mem_wdata !== e_wdata || mem_func3 !== e_f3) begin n_err++; $display("FAIL rnd_fields c=%0d got=%h/%h/%b want=%h/%h/%b", c, mem_addr, mem_wdata, mem_func3, e_addr, e_wdata, e_f3); end
            n_cmp++; if (core_rdata !== mem_rdata) begin n_err++; $display("FAIL rnd_core_rdata c=%0d got=%h want=%h", c, core_rdata, mem_rdata); end
            n_cmp++; if (dbg_rvalid !== e_rv || dbg_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_resp c=%0d got=%b/%h want=%b/%h", c, dbg_rvalid, dbg_rdata, e_rv, e_rdata); end
            n_cmp++; if (stall_cnt !== SCNT_W'(scnt)) begin n_err++; $display("FAIL rnd_stall_cnt c=%0d got=%0d want=%0d", c, stall_cnt, scnt); end

            e_rv = e_gnt && !dbg_we;
            if (e_rv) e_rdata = mem_rdata;
            wait_cyc = (e_gnt || !dbg_req) ? 0 : wait_cyc + 1;
            if (e_stall && scnt < (2**SCNT_W - 1)) scnt++;
            last_gnt = e_gnt;
            next_cycle();
        end
        set_idle();
        next_cycle();
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        #1;
        test_reset();
`ifdef DMEM_ARB_STARVE_EN
        test_starvation();
`else
        test_strict_priority();
`endif
        test_core_load();
        test_dbg_write();
        test_dbg_read();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter that shares the single data-memory/LSU port between the pipeline MEM stage and a debug/loader requester. The core has priority. A bounded-starvation counter forces a debug grant and stalls the core for exactly one cycle. Debug reads return registered data one cycle after grant. The block sits between the EX/MEM pipeline register and the `lsu`, and drives a stall back into the pipeline.

## Interface
Parameters:
- `ADDR_W`, 10, data-memory byte-address width (matches the LSU address slice).
- `DATA_W`, 32, data width.
- `STARVE_MAX`, 4, number of consecutive ungranted debug-request cycles before a forced grant (range 1..15).
- `SCNT_W`, 16, width of the stall performance counter.

Ports:
- `clk`  in  1  single clock. Everything is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `core_rd`  in  1  MEM-stage load.
- `core_wr`  in  1  MEM-stage store.
- `core_addr`  in  ADDR_W  MEM-stage address.
- `core_wdata`  in  DATA_W  MEM-stage store data.
- `core_func3`  in  3  load/store size code.
- `core_rdata`  out  DATA_W  load data to the pipeline, combinational from `mem_rdata`.
- `core_stall`  out  1  pipeline must hold MEM and earlier stages this cycle.
- `dbg_req`  in  1  debug access request, held until granted.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  ADDR_W  debug address.
- `dbg_wdata`  in  DATA_W  debug write data.
- `dbg_gnt`  out  1  debug access performed this cycle (combinational).
- `dbg_rvalid`  out  1  one-cycle pulse: `dbg_rdata` is valid.
- `dbg_rdata`  out  DATA_W  registered debug read data.
- `mem_rd`  out  1  to LSU.
- `mem_wr`  out  1  to LSU.
- `mem_addr`  out  ADDR_W  to LSU.
- `mem_wdata`  out  DATA_W  to LSU.
- `mem_func3`  out  3  to LSU.
- `mem_rdata`  in  DATA_W  LSU read data, combinational, same cycle.
- `stall_cnt`  out  SCNT_W  saturating count of forced-stall cycles.

## Operation
- `core_act = core_rd | core_wr`.
- `dbg_gnt = dbg_req & (!core_act | starve == STARVE_MAX)`.
- `core_stall = core_act & dbg_gnt`.
- Mux select:
  - When `dbg_gnt` is high, the mem port carries the debug access: `mem_rd = !dbg_we`, `mem_wr = dbg_we`, `mem_func3 = 3'b010` (word).
  - Otherwise the mem port carries the core fields unchanged. When neither side is active, `mem_rd` and `mem_wr` are 0.
- `core_rdata = mem_rdata` always. The value is meaningful only when `core_rd` is high and `core_stall` is low.
- Starvation counter `starve` (4 bits):
  - Clears when `dbg_gnt` is high or `dbg_req` is low.
  - Otherwise increments.
  - It never exceeds `STARVE_MAX`.
- Response state machine, two states:
  - `IDLE` → `RESP` on `dbg_gnt & !dbg_we`, capturing `mem_rdata` into `dbg_rdata`.
  - `RESP` → `IDLE` after one cycle, unless another read grant occurs that cycle; in that case stay in `RESP` and recapture.
- `dbg_rvalid` is high exactly while in `RESP`. `dbg_rdata` holds its value until the next capture.
- `stall_cnt` increments on each `core_stall` cycle and saturates at all-ones.
- Debug writes produce no response pulse. The requester treats `dbg_gnt` as completion.
- Simultaneous `core_rd` and `core_wr` high is illegal input. In that case the arbiter forwards both bits unchanged.

## Timing
- Reset values: `dbg_rvalid=0`, `dbg_rdata=0`, `stall_cnt=0`, `starve=0`, state `IDLE`.
- Combinational outputs follow their inputs during reset: `mem_*`, `dbg_gnt`, `core_stall`, `core_rdata`.
- Grant latency:
  - 0 cycles when the core is idle.
  - Exactly `STARVE_MAX` cycles after `dbg_req` rises under continuous core activity.
- A forced grant stalls the core for exactly 1 cycle. Because `starve` restarts from 0, the core is guaranteed at least `STARVE_MAX` consecutive cycles between forced grants.
- Debug read data arrives 1 cycle after `dbg_gnt` (`dbg_rvalid` pulse).
- Back-to-back debug reads on an idle core: `dbg_gnt` every cycle, and `dbg_rvalid` stays high continuously, one cycle delayed.
- A stalled core access is retried by the pipeline the next cycle. The arbiter keeps no core state.
- `dbg_req` dropping before grant clears `starve`. The request is abandoned and no access occurs.
- Reset mid-wait or mid-response: `starve` is cleared and any pending `dbg_rvalid` is lost. The requester re-issues after reset.

## Configuration
- Macro `DMEM_ARB_STARVE_EN`.
- Defined: starvation counter and forced grants as described above.
- Undefined:
  - Strict core priority: `dbg_gnt = dbg_req & !core_act`.
  - `core_stall` is tied to 0.
  - `starve` and `stall_cnt` logic is removed, and `stall_cnt` reads constant 0.
  - A debug requester can wait indefinitely.

## Test plan
- Reset with random inputs: after `reset`, `dbg_rvalid=0`, `dbg_rdata=0`, `stall_cnt=0`. First forced grant then occurs exactly 4 cycles after `dbg_req` with the core busy.
- Core-only load: `core_rd=1`, `core_addr=0x010`, `mem_rdata=0xCAFE0001` → `mem_rd=1`, `mem_addr=0x010`, `core_rdata=0xCAFE0001`, `core_stall=0`, `dbg_gnt=0`.
- Debug write on idle core: `dbg_req=1`, `dbg_we=1`, `dbg_addr=0x3F0`, `dbg_wdata=0xDEADBEEF` → same cycle `dbg_gnt=1`, `mem_wr=1`, `mem_addr=0x3F0`, `mem_wdata=0xDEADBEEF`, `mem_func3=3'b010`, no `dbg_rvalid`.
- Starvation (`STARVE_MAX=4`, `DMEM_ARB_STARVE_EN` defined): core active every cycle and `dbg_req` from cycle 0 → `dbg_gnt=1` and `core_stall=1` only in cycle 4, `stall_cnt=1` afterwards. Next forced grant no earlier than cycle 9.
- Debug read: grant with `mem_rdata=0x12345678` → next cycle `dbg_rvalid=1`, `dbg_rdata=0x12345678`. Following cycle `dbg_rvalid=0` and `dbg_rdata` still holds `0x12345678`.
- Macro undefined: core active for 50 cycles with `dbg_req` held → `dbg_gnt` and `core_stall` stay 0 throughout. Core goes idle → `dbg_gnt=1` in that same cycle.
